uart_tx: RTL and testbench

UART transmitter that serialises one byte per valid/ready handshake into a standard 8N1 frame (8E1 when parity is compiled in) on `tx_pin`. It is the transmit counterpart to the design's UART receiver and shares its baud arithmetic and its clocking, so a loopback of `tx_pin` into the receiver reproduces the transmitted byte. It sits between an upstream byte producer (FIFO or command logic) and the board TX pin.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_baud_cnt.sv | 25 ++
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encodings, baud counter width, bit-period formula.
package uart_tx_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } uart_state_e;

  function automatic int uart_cycle(input int clk_fre, input int baud_rate);
    return clk_fre * 1000000 / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: pulses bit_done on the last clock of each CYCLE-clock bit.
module uart_baud_cnt
  import uart_tx_pkg::*;
#(
  parameter int CYCLE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLE - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_done = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (clear || bit_done) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for 8E1.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int clk_fre   = 100,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_busy,
  output logic       tx_pin
);

  localparam int CYCLE = uart_cycle(clk_fre, baud_rate);

  uart_state_e state, state_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        pin_nxt, ready_nxt;
  logic        bit_done, hs;
`ifdef UART_TX_PARITY_EN
  logic        par, par_nxt;
`endif

  assign hs      = tx_data_valid && tx_data_ready;
  assign tx_busy = (state != S_IDLE);

  // Counter is held clear in IDLE so the start bit gets a full period from the handshake edge.
  uart_baud_cnt #(.CYCLE(CYCLE)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == S_IDLE),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      tx_pin        <= 1'b1;
      tx_data_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par           <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      shift         <= shift_nxt;
      bit_cnt       <= bit_cnt_nxt;
      tx_pin        <= pin_nxt;
      tx_data_ready <= ready_nxt;
`ifdef UART_TX_PARITY_EN
      par           <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    pin_nxt     = tx_pin;
    ready_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt     = par;
`endif
    case (state)
      S_IDLE: begin
        pin_nxt   = 1'b1;
        ready_nxt = 1'b1;
        if (hs) begin
          shift_nxt = tx_data;
          pin_nxt   = 1'b0;
          ready_nxt = 1'b0;
          state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_done) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
          pin_nxt     = shift[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
            pin_nxt   = par;
`else
            state_nxt = S_STOP;
            pin_nxt   = 1'b1;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shift_nxt   = shift >> 1;
            pin_nxt     = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_nxt = S_STOP;
          pin_nxt   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          state_nxt = S_IDLE;
          pin_nxt   = 1'b1;
          ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        pin_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CYCLE=8; parity case only when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic       tx_busy;
  logic       tx_pin;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_tx #(.clk_fre(1), .baud_rate(125000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .tx_busy       (tx_busy),
    .tx_pin        (tx_pin)
  );

  // Loopback receiver: samples mid-bit after each falling start edge.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_pin);
      repeat (12) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        b[i] = tx_pin;
        if (i < 7) repeat (8) @(negedge clk);
      end
      rx_q.push_back(b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the handshake edge; ends at the negedge after ready returns.
  task automatic frame_check(input logic [7:0] d, input string tag);
    logic e;
    int   s;
    for (int k = 0; k < NB * 8; k++) begin
      if (k > 0) @(negedge clk);
      s = k / 8;
      if (s == 0)            e = 1'b0;
      else if (s <= 8)       e = d[s-1];
      else if (s == NB - 1)  e = 1'b1;
      else                   e = ^d;
      chk($sformatf("%s_bit%0d_k%0d", tag, s, k), 32'(tx_pin), 32'(e));
      if (k == NB * 8 - 1) chk({tag, "_ready_before_end"}, 32'(tx_data_ready), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_ready_end"}, 32'(tx_data_ready), 32'd1);
    chk({tag, "_busy_end"},  32'(tx_busy),       32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    tx_data       = 8'h00;
    tx_data_valid = 1'b0;

    // Reset held 5 clocks
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_pin",   32'(tx_pin),        32'd1);
      chk("rst_ready", 32'(tx_data_ready), 32'd0);
      chk("rst_busy",  32'(tx_busy),       32'd0);
    end

    // Release with valid already high: no handshake while ready is still 0
    rst_n         = 1'b1;
    tx_data       = 8'hA5;
    tx_data_valid = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(tx_data_ready), 32'd1);
    chk("rel_busy",  32'(tx_busy),       32'd0);
    chk("rel_pin",   32'(tx_pin),        32'd1);
    @(negedge clk);
    tx_data_valid = 1'b0;
    chk("a5_ready_drop", 32'(tx_data_ready), 32'd0);
    chk("a5_busy",       32'(tx_busy),       32'd1);
    frame_check(8'hA5, "a5");

    // Back-to-back 0x00 then 0xFF
    rx_q.delete();
    tx_data       = 8'h00;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    frame_check(8'h00, "b2b0");
    chk("b2b_idle_pin", 32'(tx_pin), 32'd1);
    @(negedge clk);
    tx_data_valid = 1'b0;
    chk("b2b_start81_pin",   32'(tx_pin),        32'd0);
    chk("b2b_start81_ready", 32'(tx_data_ready), 32'd0);
    frame_check(8'hFF, "b2b1");
    chk("rx_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      chk("rx_byte0", 32'(rx_q[0]), 32'h00);
      chk("rx_byte1", 32'(rx_q[1]), 32'hFF);
    end

    // Data stability: tx_data changes mid-frame
    tx_data       = 8'h81;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data       = 8'h3C;
    tx_data_valid = 1'b0;
    frame_check(8'h81, "stab");

    // Reset during bit 3 of 0x55
    tx_data       = 8'h55;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    repeat (35) @(negedge clk);
    chk("mid_bit3_pin", 32'(tx_pin), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_pin",   32'(tx_pin),        32'd1);
    chk("mid_rst_ready", 32'(tx_data_ready), 32'd0);
    chk("mid_rst_busy",  32'(tx_busy),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(tx_data_ready), 32'd1);
    tx_data       = 8'h12;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    frame_check(8'h12, "after_rst");

`ifdef UART_TX_PARITY_EN
    tx_data       = 8'h07;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    frame_check(8'h07, "par07");
`endif

    // Idle line stays high with no request
    repeat (3) @(negedge clk);
    chk("idle_pin",   32'(tx_pin),        32'd1);
    chk("idle_ready", 32'(tx_data_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
